// File: rtl/line_window_gen.sv
// 3x3 sliding-window generator for a raster stream: two circular line buffers feed
// a 3x3 register window; only interior windows are flagged valid.
module line_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] xm1ym1,
    output logic [7:0] xm1y0,
    output logic [7:0] xm1yp1,
    output logic [7:0] x0ym1,
    output logic [7:0] x0y0,
    output logic [7:0] x0yp1,
    output logic [7:0] xp1ym1,
    output logic [7:0] xp1y0,
    output logic [7:0] xp1yp1,
    output logic       win_valid,
    output logic       frame_done,
    output logic       sof_err
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // L1 holds the previous row, L2 the row before that; never cleared
    logic [7:0] r_l1 [IMG_W];
    logic [7:0] r_l2 [IMG_W];

    logic [7:0] r_xm1ym1, r_xm1y0, r_xm1yp1;
    logic [7:0] r_x0ym1,  r_x0y0,  r_x0yp1;
    logic [7:0] r_xp1ym1, r_xp1y0, r_xp1yp1;
    logic       r_win_valid;
    logic       r_frame_done;
    logic       r_sof_err;

    logic             w_restart;
    logic             w_accept;
    logic             w_sof_mid;
    logic [ROW_W-1:0] w_row_a;
    logic [COL_W-1:0] w_col_a;
    logic             w_last;
    logic             w_interior;
    logic [7:0]       w_l1_rd;
    logic [7:0]       w_l2_rd;

    // A sof pixel always lands at (0,0), whatever the counters say
    assign w_restart  = pix_valid & sof;
    assign w_accept   = pix_valid & (sof | (r_state == ACTIVE));
    assign w_sof_mid  = w_restart & (r_state == ACTIVE) &
                        ((r_row != '0) | (r_col != '0));
    assign w_row_a    = w_restart ? '0 : r_row;
    assign w_col_a    = w_restart ? '0 : r_col;
    assign w_last     = (w_row_a == ROW_LAST) && (w_col_a == COL_LAST);
    assign w_interior = (w_row_a >= ROW_TWO) && (w_col_a >= COL_TWO);
    assign w_l1_rd    = r_l1[w_col_a];
    assign w_l2_rd    = r_l2[w_col_a];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_l2[w_col_a] <= w_l1_rd;
            r_l1[w_col_a] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_xm1ym1     <= '0;
            r_xm1y0      <= '0;
            r_xm1yp1     <= '0;
            r_x0ym1      <= '0;
            r_x0y0       <= '0;
            r_x0yp1      <= '0;
            r_xp1ym1     <= '0;
            r_xp1y0      <= '0;
            r_xp1yp1     <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
            if (w_accept) begin
                r_xm1ym1     <= r_x0ym1;
                r_xm1y0      <= r_x0y0;
                r_xm1yp1     <= r_x0yp1;
                r_x0ym1      <= r_xp1ym1;
                r_x0y0       <= r_xp1y0;
                r_x0yp1      <= r_xp1yp1;
                r_xp1ym1     <= w_l2_rd;
                r_xp1y0      <= w_l1_rd;
                r_xp1yp1     <= pix_in;
                r_win_valid  <= w_interior;
                r_frame_done <= w_last;
                r_sof_err    <= w_sof_mid;
                if (w_last) begin
                    r_state <= IDLE;
                    r_row   <= '0;
                    r_col   <= '0;
                end else begin
                    r_state <= ACTIVE;
                    if (w_col_a == COL_LAST) begin
                        r_col <= '0;
                        r_row <= w_row_a + ROW_W'(1);
                    end else begin
                        r_col <= w_col_a + COL_W'(1);
                        r_row <= w_row_a;
                    end
                end
            end
        end
    end

    assign xm1ym1     = r_xm1ym1;
    assign xm1y0      = r_xm1y0;
    assign xm1yp1     = r_xm1yp1;
    assign x0ym1      = r_x0ym1;
    assign x0y0       = r_x0y0;
    assign x0yp1      = r_x0yp1;
    assign xp1ym1     = r_xp1ym1;
    assign xp1y0      = r_xp1y0;
    assign xp1yp1     = r_xp1yp1;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per line (range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 64, lines per frame (range 3..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-005 SHALL have port pix_in  input  8  raster pixel, unsigned.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on this edge.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid.
REQ-008 SHALL have ports xm1ym1, xm1y0, xm1yp1, x0ym1, x0y0, x0yp1, xp1ym1, xp1y0, xp1yp1  output  8 each  3x3 window feeding the downstream median stage; x is the column offset (xp1 = newest column) and y is the row offset (yp1 = newest row).
REQ-009 SHALL have port win_valid  output  1  window registers hold a complete interior window.
REQ-010 SHALL have port frame_done  output  1  pulse after the last pixel of a frame.
REQ-011 SHALL have port sof_err  output  1  pulse on sof received mid-frame.

Function
REQ-012 SHALL have FSM states IDLE and ACTIVE.
REQ-013 SHALL ignore pixels in IDLE unless pix_valid=1 and sof=1; that pixel SHALL be accepted as (row 0, col 0) and the FSM SHALL enter ACTIVE.
REQ-014 SHALL, in ACTIVE, accept every pixel with pix_valid=1 (no backpressure), advancing col 0..IMG_W-1; at col=IMG_W-1 col SHALL wrap to 0 and row SHALL increment.
REQ-015 SHALL implement two circular line buffers of IMG_W x 8 bits, indexed by col: L1 = previous row, L2 = two rows back.
REQ-016 SHALL, on each accept: shift the window one column left (xm1* <= x0*, x0* <= xp1*), load xp1ym1 <= L2[col], xp1y0 <= L1[col], xp1yp1 <= pix_in, write L2[col] <= L1[col] and L1[col] <= pix_in.
REQ-017 SHALL assert win_valid for exactly one cycle, the cycle after accepting a pixel with row>=2 and col>=2; window centre x0y0 is then pixel (row-1, col-1).
REQ-018 SHALL produce no border windows and no padding: exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per frame.
REQ-019 SHALL hold window outputs unchanged and keep win_valid=0 in cycles with no accept (pix_valid gaps).
REQ-020 SHALL, after accepting pixel (IMG_H-1, IMG_W-1), pulse frame_done for one cycle (coincident with the last win_valid), reset row/col to 0, and return to IDLE.
REQ-021 SHALL accept a sof pixel in the very next cycle after the last pixel of a frame (back-to-back frames, no dead cycle).
REQ-022 SHALL, on pix_valid=1 with sof=1 in ACTIVE at any position other than (0,0), accept the pixel as (0,0), restart counters, pulse sof_err for one cycle, and not pulse frame_done.
REQ-023 SHALL ignore sof when pix_valid=0.
REQ-024 SHALL NOT clear line buffer contents on reset or sof; stale data never reaches win_valid windows because rows 0-1 are never emitted.

Reset
REQ-025 SHALL, on rst=0 at a clock edge, set state IDLE, row=0, col=0, all nine window outputs to 0, and win_valid, frame_done, sof_err to 0, regardless of pix_valid/sof in that cycle.
REQ-026 SHALL, when reset is applied mid-frame, discard the partial frame; after release, pixels are ignored until the next sof.

Verification (IMG_W=5, IMG_H=5, pixel value = row*16+col)
REQ-027 SHALL test a continuous frame from sof: first win_valid the cycle after accepting pixel (2,2), with xm1ym1=0, x0y0=17, xp1yp1=34, xp1ym1=2; 9 win_valid pulses total; frame_done coincident with the last pulse, whose x0y0=51.
REQ-028 SHALL test the same frame with pix_valid toggling 1,0,1,0: identical window values and 9 pulses, outputs held during gaps.
REQ-029 SHALL test 3 pixels with pix_valid=1, sof=0 after reset, then a frame: the 3 pixels are ignored and results match REQ-027.
REQ-030 SHALL test sof at row 1 col 3 mid-frame: one-cycle sof_err pulse, no frame_done, then 9 correct windows from the restart.
REQ-031 SHALL test rst=0 after pixel (3,1): next cycle all outputs are 0; the following sof frame gives results per REQ-027.
REQ-032 SHALL test two back-to-back frames, the second with value+100: 18 win_valid pulses, 2 frame_done pulses, and the first window of frame 2 has x0y0=117.
